// File: rtl/axi_protocol_checker_if.sv
// AXI3 channel bundle shared by masters, slaves and passive observers.
// The monitor modport is for components that only watch the bus.
interface axi_protocol_checker_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  AWVALID, AWREADY;
  logic [ID_WIDTH-1:0]   AWID;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [3:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic [1:0]            AWBURST;

  logic                  WVALID, WREADY, WLAST;
  logic [ID_WIDTH-1:0]   WID;
  logic [DATA_WIDTH-1:0] WDATA;
  logic [STRB_WIDTH-1:0] WSTRB;

  logic                  BVALID, BREADY;
  logic [ID_WIDTH-1:0]   BID;
  logic [1:0]            BRESP;

  logic                  ARVALID, ARREADY;
  logic [ID_WIDTH-1:0]   ARID;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [3:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;

  logic                  RVALID, RREADY, RLAST;
  logic [ID_WIDTH-1:0]   RID;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;

  modport master (
    output AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST,
    output WVALID, WLAST, WID, WDATA, WSTRB, BREADY,
    output ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, RREADY,
    input  AWREADY, WREADY, BVALID, BID, BRESP, ARREADY,
    input  RVALID, RLAST, RID, RDATA, RRESP
  );

  modport slave (
    input  AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST,
    input  WVALID, WLAST, WID, WDATA, WSTRB, BREADY,
    input  ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, RREADY,
    output AWREADY, WREADY, BVALID, BID, BRESP, ARREADY,
    output RVALID, RLAST, RID, RDATA, RRESP
  );

  modport monitor (
    input AWVALID, AWREADY, AWID, AWADDR, AWLEN, AWSIZE, AWBURST,
    input WVALID, WREADY, WLAST, WID, WDATA, WSTRB,
    input BVALID, BREADY, BID, BRESP,
    input ARVALID, ARREADY, ARID, ARADDR, ARLEN, ARSIZE, ARBURST,
    input RVALID, RREADY, RLAST, RID, RDATA, RRESP
  );
endinterface

// File: rtl/axi_protocol_checker.sv
// Passive AXI3 protocol checker: tracks outstanding bursts in small FIFOs and
// flags handshake, LAST, ID-ordering, overflow and burst-encoding violations.

module axi_protocol_checker_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full queue is accepted only when a pop frees the slot.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are live.
  always_ff @(posedge ACLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

module axi_protocol_checker #(
  parameter int ID_WIDTH        = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                               ACLK,
  input  logic                               ARESET,
  axi_protocol_checker_if.monitor            bus,
  output logic                               err_valid,
  output logic [3:0]                         err_code,
  output logic [11:0]                        err_sticky,
  output logic [$clog2(MAX_OUTSTANDING):0]   wr_outstanding,
  output logic [$clog2(MAX_OUTSTANDING):0]   rd_outstanding
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CW         = $clog2(MAX_OUTSTANDING) + 1;
  localparam int AP_W       = ID_WIDTH + ADDR_WIDTH + 9;
  localparam int WP_W       = ID_WIDTH + DATA_WIDTH + STRB_WIDTH + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  localparam int R_AW_STABLE = 0, R_W_STABLE = 1, R_AR_STABLE = 2, R_WLAST = 3;
  localparam int R_RLAST = 4, R_WID = 5, R_RID = 6, R_W_EARLY = 7, R_B_ERR = 8;
  localparam int R_R_UNEXP = 9, R_OVERFLOW = 10, R_BURST = 11;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, w_done, r_done;
  assign aw_hs  = bus.AWVALID && bus.AWREADY;
  assign w_hs   = bus.WVALID  && bus.WREADY;
  assign b_hs   = bus.BVALID  && bus.BREADY;
  assign ar_hs  = bus.ARVALID && bus.ARREADY;
  assign r_hs   = bus.RVALID  && bus.RREADY;
  assign w_done = w_hs && bus.WLAST;
  assign r_done = r_hs && bus.RLAST;

  logic [ID_WIDTH+3:0] awq_head, arq_head;
  logic [ID_WIDTH-1:0] awq_id, arq_id, bq_id;
  logic [3:0]          awq_len, arq_len;
  logic awq_empty, awq_full, bq_empty, bq_full, arq_empty, arq_full;

  assign {awq_id, awq_len} = awq_head;
  assign {arq_id, arq_len} = arq_head;

  axi_protocol_checker_fifo #(.WIDTH(ID_WIDTH + 4), .DEPTH(MAX_OUTSTANDING)) u_awq (
    .ACLK, .ARESET, .push(aw_hs), .pop(w_done), .din({bus.AWID, bus.AWLEN}),
    .head(awq_head), .empty(awq_empty), .full(awq_full));

  axi_protocol_checker_fifo #(.WIDTH(ID_WIDTH), .DEPTH(MAX_OUTSTANDING)) u_bq (
    .ACLK, .ARESET, .push(w_done && !awq_empty), .pop(b_hs), .din(awq_id),
    .head(bq_id), .empty(bq_empty), .full(bq_full));

  axi_protocol_checker_fifo #(.WIDTH(ID_WIDTH + 4), .DEPTH(MAX_OUTSTANDING)) u_arq (
    .ACLK, .ARESET, .push(ar_hs), .pop(r_done), .din({bus.ARID, bus.ARLEN}),
    .head(arq_head), .empty(arq_empty), .full(arq_full));

  logic [AP_W-1:0] aw_payload, aw_prev, ar_payload, ar_prev;
  logic [WP_W-1:0] w_payload, w_prev;
  logic            aw_pend, w_pend, ar_pend;
  logic [4:0]      wbeat, rbeat;
  logic [11:0]     rules;
  logic [3:0]      code_d;
  logic            unused_inputs;

  assign aw_payload    = {bus.AWID, bus.AWADDR, bus.AWLEN, bus.AWSIZE, bus.AWBURST};
  assign ar_payload    = {bus.ARID, bus.ARADDR, bus.ARLEN, bus.ARSIZE, bus.ARBURST};
  assign w_payload     = {bus.WID, bus.WDATA, bus.WSTRB, bus.WLAST};
  assign unused_inputs = ^{bus.BRESP, bus.RDATA, bus.RRESP, bq_full};

  function automatic logic bad_burst(input logic [1:0] burst, input logic [3:0] len);
    return (burst == 2'b11) || (burst == 2'b10 && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
  endfunction

  function automatic logic [CW-1:0] bump(input logic [CW-1:0] cnt, input logic inc, input logic dec);
    if (inc && !dec) return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    if (dec && !inc) return (cnt == '0) ? cnt : cnt - 1'b1;
    return cnt;
  endfunction

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    rules = '0;
    rules[R_AW_STABLE] = aw_pend && (!bus.AWVALID || aw_payload != aw_prev);
    rules[R_W_STABLE]  = w_pend  && (!bus.WVALID  || w_payload  != w_prev);
    rules[R_AR_STABLE] = ar_pend && (!bus.ARVALID || ar_payload != ar_prev);
    if (w_hs) begin
      rules[R_W_EARLY] = awq_empty;
      rules[R_WLAST]   = !awq_empty && (bus.WLAST != (wbeat == {1'b0, awq_len}));
      rules[R_WID]     = !awq_empty && (bus.WID != awq_id);
    end
    if (r_hs) begin
      rules[R_R_UNEXP] = arq_empty;
      rules[R_RLAST]   = !arq_empty && (bus.RLAST != (rbeat == {1'b0, arq_len}));
      rules[R_RID]     = !arq_empty && (bus.RID != arq_id);
    end
    rules[R_B_ERR]    = b_hs && (bq_empty || bus.BID != bq_id);
    rules[R_OVERFLOW] = (aw_hs && awq_full && !w_done) || (ar_hs && arq_full && !r_done);
    rules[R_BURST]    = (aw_hs && bad_burst(bus.AWBURST, bus.AWLEN)) ||
                        (ar_hs && bad_burst(bus.ARBURST, bus.ARLEN));

    code_d = '0;
    for (int i = 11; i >= 0; i--) begin
      if (rules[i]) code_d = 4'(i + 1);
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_pend        <= 1'b0;
      w_pend         <= 1'b0;
      ar_pend        <= 1'b0;
      aw_prev        <= '0;
      w_prev         <= '0;
      ar_prev        <= '0;
      wbeat          <= '0;
      rbeat          <= '0;
      err_valid      <= 1'b0;
      err_code       <= '0;
      err_sticky     <= '0;
      wr_outstanding <= '0;
      rd_outstanding <= '0;
    end else begin
      aw_pend <= bus.AWVALID && !bus.AWREADY;
      w_pend  <= bus.WVALID  && !bus.WREADY;
      ar_pend <= bus.ARVALID && !bus.ARREADY;
      aw_prev <= aw_payload;
      w_prev  <= w_payload;
      ar_prev <= ar_payload;
      // Beats with no burst to attribute them to are not counted.
      if (w_hs) begin
        if (bus.WLAST)                         wbeat <= '0;
        else if (!awq_empty && wbeat != 5'h1f) wbeat <= wbeat + 1'b1;
      end
      if (r_hs) begin
        if (bus.RLAST)                         rbeat <= '0;
        else if (!arq_empty && rbeat != 5'h1f) rbeat <= rbeat + 1'b1;
      end
      err_valid      <= |rules;
      err_code       <= code_d;
      err_sticky     <= err_sticky | rules;
      wr_outstanding <= bump(wr_outstanding, aw_hs, b_hs);
      rd_outstanding <= bump(rd_outstanding, ar_hs, r_done);
    end
  end
endmodule

// File: tb/tb_axi_protocol_checker.sv
// Directed bench for axi_protocol_checker: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_axi_protocol_checker;
  localparam logic [1:0] INCR = 2'b01;
  localparam logic [1:0] WRAP = 2'b10;

  typedef struct {
    string      name;
    logic [3:0] code;
    logic [11:0] sticky;
    logic [3:0] wr;
    logic [3:0] rd;
  } exp_t;

  logic        ACLK;
  logic        ARESET;
  logic        err_valid;
  logic [3:0]  err_code;
  logic [11:0] err_sticky;
  logic [3:0]  wr_outstanding, rd_outstanding;

  exp_t        sb[$];
  logic [11:0] exp_sticky;
  int          n_checks;
  int          n_fail;

  axi_protocol_checker_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_protocol_checker #(
    .ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(8)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .bus(bus),
    .err_valid(err_valid), .err_code(err_code), .err_sticky(err_sticky),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {vld,code,sticky,wr,rd}=%h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge ACLK) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, {err_valid, err_code, err_sticky, wr_outstanding, rd_outstanding},
            {(e.code != 4'd0), e.code, e.sticky, e.wr, e.rd});
    end
  end

  task automatic tick(input string name, input logic [3:0] code, input logic [11:0] bits,
                      input logic [3:0] wr, input logic [3:0] rd);
    exp_t e;
    @(posedge ACLK);
    exp_sticky = ARESET ? 12'h000 : (exp_sticky | bits);
    e.name = name; e.code = code; e.sticky = exp_sticky; e.wr = wr; e.rd = rd;
    sb.push_back(e);
    @(negedge ACLK);
  endtask

  task automatic idle();
    bus.AWVALID = 0; bus.AWREADY = 0; bus.WVALID = 0; bus.WREADY = 0;
    bus.BVALID  = 0; bus.BREADY  = 0; bus.ARVALID = 0; bus.ARREADY = 0;
    bus.RVALID  = 0; bus.RREADY  = 0;
  endtask

  task automatic drive_aw(input logic v, input logic rdy, input logic [3:0] id,
                          input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst);
    bus.AWVALID = v; bus.AWREADY = rdy; bus.AWID = id; bus.AWADDR = addr;
    bus.AWLEN = len; bus.AWSIZE = 3'd2; bus.AWBURST = burst;
  endtask

  task automatic drive_w(input logic v, input logic rdy, input logic [3:0] id, input logic last);
    bus.WVALID = v; bus.WREADY = rdy; bus.WID = id; bus.WLAST = last;
    bus.WDATA = {28'h0, id}; bus.WSTRB = 4'hf;
  endtask

  task automatic drive_b(input logic v, input logic [3:0] id);
    bus.BVALID = v; bus.BREADY = 1'b1; bus.BID = id; bus.BRESP = 2'b00;
  endtask

  task automatic drive_ar(input logic v, input logic rdy, input logic [3:0] id,
                          input logic [3:0] len, input logic [1:0] burst);
    bus.ARVALID = v; bus.ARREADY = rdy; bus.ARID = id; bus.ARADDR = 32'h8000;
    bus.ARLEN = len; bus.ARSIZE = 3'd2; bus.ARBURST = burst;
  endtask

  task automatic drive_r(input logic v, input logic [3:0] id, input logic last);
    bus.RVALID = v; bus.RREADY = 1'b1; bus.RID = id; bus.RLAST = last;
    bus.RDATA = 32'h0; bus.RRESP = 2'b00;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; exp_sticky = '0;
    ARESET = 1'b1;
    drive_aw(0, 0, 0, 0, 0, INCR); drive_w(0, 0, 0, 0); drive_b(0, 0);
    drive_ar(0, 0, 0, 0, INCR); drive_r(0, 0, 0); idle();
    tick("reset0", 0, 0, 0, 0);
    tick("reset1", 0, 0, 0, 0);
    ARESET = 1'b0;

    // Legal write burst of four beats, then a single-beat read.
    drive_aw(1, 1, 3, 32'h1000, 3, INCR); tick("legal_aw", 0, 0, 1, 0);
    idle();
    for (int i = 0; i < 4; i++) begin
      drive_w(1, 1, 3, (i == 3)); tick($sformatf("legal_w%0d", i), 0, 0, 1, 0);
    end
    idle(); drive_b(1, 3);              tick("legal_b", 0, 0, 0, 0);
    idle(); drive_ar(1, 1, 1, 0, INCR); tick("legal_ar", 0, 0, 0, 1);
    idle(); drive_r(1, 1, 1);           tick("legal_r", 0, 0, 0, 0);
    idle();                             tick("legal_idle", 0, 0, 0, 0);

    // AW payload changes while stalled.
    drive_aw(1, 0, 0, 32'h100, 0, INCR); tick("stall_hold", 0, 0, 0, 0);
    drive_aw(1, 0, 0, 32'h104, 0, INCR); tick("stall_addr_change", 1, 12'h001, 0, 0);
    drive_aw(1, 1, 0, 32'h104, 0, INCR); tick("stall_accept", 0, 0, 1, 0);
    idle(); drive_w(1, 1, 0, 1);         tick("stall_w", 0, 0, 1, 0);
    idle(); drive_b(1, 0);               tick("stall_b", 0, 0, 0, 0);

    // Early WLAST, then the next burst must check clean.
    idle(); drive_aw(1, 1, 4, 32'h2000, 3, INCR); tick("early_aw", 0, 0, 1, 0);
    idle(); drive_w(1, 1, 4, 0);                  tick("early_w0", 0, 0, 1, 0);
    drive_w(1, 1, 4, 1);                          tick("early_wlast", 4, 12'h008, 1, 0);
    idle(); drive_aw(1, 1, 5, 32'h3000, 0, INCR); tick("resync_aw", 0, 0, 2, 0);
    idle(); drive_w(1, 1, 5, 1);                  tick("resync_w", 0, 0, 2, 0);
    idle(); drive_b(1, 4);                        tick("resync_b4", 0, 0, 1, 0);
    drive_b(1, 5);                                tick("resync_b5", 0, 0, 0, 0);

    // Out-of-order read data.
    idle(); drive_ar(1, 1, 2, 0, INCR); tick("order_ar2", 0, 0, 0, 1);
    drive_ar(1, 1, 5, 0, INCR);         tick("order_ar5", 0, 0, 0, 2);
    idle(); drive_r(1, 5, 1);           tick("order_r5_early", 7, 12'h040, 0, 1);
    drive_r(1, 5, 1);                   tick("order_r5", 0, 0, 0, 0);

    // Nine writes into an eight-deep queue with nothing draining it.
    for (int i = 0; i < 8; i++) begin
      idle(); drive_aw(1, 1, 4'(i), 32'h100 * i, 0, INCR);
      tick($sformatf("ovf_aw%0d", i), 0, 0, 4'(i + 1), 0);
    end
    idle(); drive_aw(1, 1, 8, 32'h900, 0, INCR); tick("ovf_ninth", 11, 12'h400, 8, 0);
    for (int i = 0; i < 8; i++) begin
      idle(); drive_w(1, 1, 4'(i), 1); tick($sformatf("ovf_w%0d", i), 0, 0, 8, 0);
    end
    for (int i = 0; i < 8; i++) begin
      idle(); drive_b(1, 4'(i)); tick($sformatf("ovf_b%0d", i), 0, 0, 4'(7 - i), 0);
    end

    // Same fill, but the ninth address lands together with a draining WLAST.
    for (int i = 0; i < 8; i++) begin
      idle(); drive_aw(1, 1, 4'(i), 32'h100 * i, 0, INCR);
      tick($sformatf("pop_aw%0d", i), 0, 0, 4'(i + 1), 0);
    end
    idle(); drive_aw(1, 1, 8, 32'h900, 0, INCR); drive_w(1, 1, 0, 1);
    tick("pop_ninth", 0, 0, 8, 0);
    for (int i = 1; i <= 8; i++) begin
      idle(); drive_w(1, 1, 4'(i), 1); drive_b(1, 4'(i - 1));
      tick($sformatf("pop_wb%0d", i), 0, 0, 4'(8 - i), 0);
    end
    idle(); drive_b(1, 8); tick("pop_last_b", 0, 0, 0, 0);

    // Burst encodings, combined with a dropped W valid.
    idle(); drive_aw(1, 1, 6, 32'h4000, 2, WRAP); tick("wrap_len2", 12, 12'h800, 1, 0);
    idle(); drive_w(1, 0, 0, 1);                  tick("w_stall", 0, 0, 1, 0);
    idle(); drive_aw(1, 1, 7, 32'h5000, 2, WRAP); tick("wrap_and_w_drop", 2, 12'h802, 2, 0);
    idle(); drive_aw(1, 1, 8, 32'h6000, 3, WRAP); tick("wrap_len3", 0, 0, 3, 0);
    idle(); drive_ar(1, 1, 1, 0, 2'b11);          tick("ar_burst_rsvd", 12, 12'h800, 3, 1);

    // Reset with traffic pending, then orphan beats after release.
    idle(); ARESET = 1'b1; drive_aw(1, 0, 0, 32'h200, 0, INCR); tick("reset_mid", 0, 0, 0, 0);
    ARESET = 1'b0; idle();          tick("reset_release", 0, 0, 0, 0);
    drive_w(1, 1, 6, 0);            tick("w_early", 8, 12'h080, 0, 0);
    idle(); drive_r(1, 1, 1);       tick("r_unexp", 10, 12'h200, 0, 0);
    idle(); drive_b(1, 0);          tick("b_unexp", 9, 12'h100, 0, 0);
    idle();                         tick("sticky_hold", 0, 0, 0, 0);
    ARESET = 1'b1;                  tick("final_reset", 0, 0, 0, 0);

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge ACLK);
    @(posedge ACLK);
    check("scoreboard_drain", 25'(sb.size()), 25'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
